// File: rtl/cache_pkg.sv
// Shared geometry, FSM state encoding and address helper for the cache controller.
package cache_pkg;

    localparam int ADDR_W   = 16;
    localparam int BLOCK_W  = 256;
    localparam int OFFSET_W = 5;
    localparam int WORD_W   = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        REFILL,
        INSTALL,
        RESPOND
    } state_e;

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// CPU, cache-array and memory signals of the cache controller.
// master = controller side, slave = CPU/cache/memory environment side.
interface cache_ctrl_if #(
    parameter int BLOCK_W = cache_pkg::BLOCK_W,
    parameter int CNT_W   = 16
);
    import cache_pkg::*;

    logic                cpu_req_valid;
    logic                cpu_req_we;
    logic [ADDR_W-1:0]   cpu_addr;
    logic [WORD_W-1:0]   cpu_wdata;
    logic                cpu_ready;
    logic                cpu_resp_valid;
    logic [WORD_W-1:0]   cpu_rdata;

    logic                c_read_en;
    logic                c_write_en;
    logic [ADDR_W-1:0]   c_address;
    logic [WORD_W-1:0]   c_write_data;
    logic [WORD_W-1:0]   c_read_data;
    logic                c_hit;
    logic                c_miss;
    logic                c_need_wb;
    logic [ADDR_W-1:0]   c_wb_address;
    logic [BLOCK_W-1:0]  c_wb_block;
    logic [BLOCK_W-1:0]  c_refill_block;
    logic                c_refill_done;

    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [BLOCK_W-1:0]  mem_wdata;
    logic [BLOCK_W-1:0]  mem_rdata;
    logic                mem_ack;

    logic [CNT_W-1:0]    hit_cnt;
    logic [CNT_W-1:0]    miss_cnt;
    logic [CNT_W-1:0]    wb_cnt;

    modport master (
        input  cpu_req_valid, cpu_req_we, cpu_addr, cpu_wdata,
        input  c_read_data, c_hit, c_miss, c_need_wb, c_wb_address, c_wb_block,
        input  mem_rdata, mem_ack,
        output cpu_ready, cpu_resp_valid, cpu_rdata,
        output c_read_en, c_write_en, c_address, c_write_data, c_refill_block, c_refill_done,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output hit_cnt, miss_cnt, wb_cnt
    );

    modport slave (
        output cpu_req_valid, cpu_req_we, cpu_addr, cpu_wdata,
        output c_read_data, c_hit, c_miss, c_need_wb, c_wb_address, c_wb_block,
        output mem_rdata, mem_ack,
        input  cpu_ready, cpu_resp_valid, cpu_rdata,
        input  c_read_en, c_write_en, c_address, c_write_data, c_refill_block, c_refill_done,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  hit_cnt, miss_cnt, wb_cnt
    );

endinterface

// File: rtl/cache_ctrl_sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_inc && !(&r_cnt))
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/cache_ctrl.sv
// Blocking cache controller: lookup, optional victim writeback, refill, install,
// then a retried lookup that completes the original access.
module cache_ctrl #(
    parameter int BLOCK_W = cache_pkg::BLOCK_W,
    parameter int CNT_W   = 16
) (
    input  logic         clk,
    input  logic         rst,
    cache_ctrl_if.master bus
);
    import cache_pkg::*;

    state_e              r_state, w_next;
    logic [ADDR_W-1:0]   r_addr, r_wb_addr;
    logic [WORD_W-1:0]   r_wdata, r_rdata;
    logic [BLOCK_W-1:0]  r_wb_block, r_refill_block;
    logic                r_we, r_retry;
    logic                w_lookup, w_miss, w_hit_inc, w_miss_inc, w_wb_inc;
    logic [CNT_W-1:0]    w_hit_cnt, w_miss_cnt, w_wb_cnt;

    // The retried lookup after an install must not count the request a second time.
    assign w_lookup   = (r_state == LOOKUP);
    assign w_miss     = w_lookup && !bus.c_hit && bus.c_miss;
    assign w_hit_inc  = w_lookup && bus.c_hit && !r_retry;
    assign w_miss_inc = w_miss && !r_retry;
    assign w_wb_inc   = w_miss_inc && bus.c_need_wb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next             = r_state;
        bus.cpu_ready      = 1'b0;
        bus.cpu_resp_valid = 1'b0;
        bus.c_read_en      = 1'b0;
        bus.c_write_en     = 1'b0;
        bus.c_refill_done  = 1'b0;
        bus.mem_req        = 1'b0;
        bus.mem_we         = 1'b0;
        bus.mem_addr       = '0;
        case (r_state)
            IDLE: begin
                bus.cpu_ready = 1'b1;
                if (bus.cpu_req_valid) w_next = LOOKUP;
            end
            LOOKUP: begin
                bus.c_read_en  = !r_we;
                bus.c_write_en = r_we;
                if (bus.c_hit)  w_next = RESPOND;
                else if (bus.c_miss) w_next = bus.c_need_wb ? WRITEBACK : REFILL;
            end
            WRITEBACK: begin
                bus.mem_req  = 1'b1;
                bus.mem_we   = 1'b1;
                bus.mem_addr = r_wb_addr;
                if (bus.mem_ack) w_next = REFILL;
            end
            REFILL: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = line_base(r_addr);
                if (bus.mem_ack) w_next = INSTALL;
            end
            INSTALL: begin
                bus.c_refill_done = 1'b1;
                w_next            = LOOKUP;
            end
            RESPOND: begin
                bus.cpu_resp_valid = 1'b1;
                w_next             = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr         <= '0;
            r_we           <= 1'b0;
            r_wdata        <= '0;
            r_retry        <= 1'b0;
            r_rdata        <= '0;
            r_wb_addr      <= '0;
            r_wb_block     <= '0;
            r_refill_block <= '0;
        end else begin
            if (r_state == IDLE && bus.cpu_req_valid) begin
                r_addr  <= bus.cpu_addr;
                r_we    <= bus.cpu_req_we;
                r_wdata <= bus.cpu_wdata;
                r_retry <= 1'b0;
            end
            if (w_lookup && bus.c_hit && !r_we)
                r_rdata <= bus.c_read_data;
            if (w_miss && bus.c_need_wb) begin
                r_wb_addr  <= bus.c_wb_address;
                r_wb_block <= bus.c_wb_block;
            end
            if (r_state == REFILL && bus.mem_ack)
                r_refill_block <= bus.mem_rdata;
            if (r_state == INSTALL)
                r_retry <= 1'b1;
        end
    end

    assign bus.c_address      = r_addr;
    assign bus.c_write_data   = r_wdata;
    assign bus.cpu_rdata      = r_rdata;
    assign bus.mem_wdata      = r_wb_block;
    assign bus.c_refill_block = r_refill_block;

    sat_counter #(.CNT_W(CNT_W)) u_hit_cnt  (.clk(clk), .rst(rst), .i_inc(w_hit_inc),  .o_cnt(w_hit_cnt));
    sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (.clk(clk), .rst(rst), .i_inc(w_miss_inc), .o_cnt(w_miss_cnt));
    sat_counter #(.CNT_W(CNT_W)) u_wb_cnt   (.clk(clk), .rst(rst), .i_inc(w_wb_inc),   .o_cnt(w_wb_cnt));

    assign bus.hit_cnt  = w_hit_cnt;
    assign bus.miss_cnt = w_miss_cnt;
    assign bus.wb_cnt   = w_wb_cnt;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a small direct-mapped cache model and a hand-driven memory.
module tb_cache_ctrl;

    localparam int BW = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_ctrl_if #(.BLOCK_W(BW), .CNT_W(16)) if0 ();
    cache_ctrl_if #(.BLOCK_W(BW), .CNT_W(2))  if1 ();

    cache_ctrl #(.BLOCK_W(BW), .CNT_W(16)) dut     (.clk(clk), .rst(rst), .bus(if0));
    // Narrow-counter copy fed the same inputs, so saturation is reachable in a few requests.
    cache_ctrl #(.BLOCK_W(BW), .CNT_W(2))  dut_sat (.clk(clk), .rst(rst), .bus(if1));

    assign if1.cpu_req_valid = if0.cpu_req_valid;
    assign if1.cpu_req_we    = if0.cpu_req_we;
    assign if1.cpu_addr      = if0.cpu_addr;
    assign if1.cpu_wdata     = if0.cpu_wdata;
    assign if1.c_read_data   = if0.c_read_data;
    assign if1.c_hit         = if0.c_hit;
    assign if1.c_miss        = if0.c_miss;
    assign if1.c_need_wb     = if0.c_need_wb;
    assign if1.c_wb_address  = if0.c_wb_address;
    assign if1.c_wb_block    = if0.c_wb_block;
    assign if1.mem_rdata     = if0.mem_rdata;
    assign if1.mem_ack       = if0.mem_ack;

    // Direct-mapped cache: 32 lines of 32 bytes, index addr[9:5], tag addr[15:10].
    logic [BW-1:0] cm_data [32];
    logic [5:0]    cm_tag  [32];
    logic [31:0]   cm_vld, cm_dirty;
    logic          cm_init;
    logic [4:0]    w_idx;
    logic [5:0]    w_tag;
    logic [2:0]    w_word;

    assign w_idx  = if0.c_address[9:5];
    assign w_tag  = if0.c_address[15:10];
    assign w_word = if0.c_address[4:2];

    always_comb begin
        if0.c_hit        = 1'b0;
        if0.c_miss       = 1'b0;
        if0.c_need_wb    = 1'b0;
        if0.c_read_data  = '0;
        if0.c_wb_address = '0;
        if0.c_wb_block   = '0;
        if (if0.c_read_en || if0.c_write_en) begin
            if (cm_vld[w_idx] && cm_tag[w_idx] == w_tag) begin
                if0.c_hit       = 1'b1;
                if0.c_read_data = cm_data[w_idx][{w_word, 5'd0} +: 32];
            end else begin
                if0.c_miss       = 1'b1;
                if0.c_need_wb    = cm_vld[w_idx] && cm_dirty[w_idx];
                if0.c_wb_address = {cm_tag[w_idx], w_idx, 5'd0};
                if0.c_wb_block   = cm_data[w_idx];
            end
        end
    end

    always @(posedge clk) begin
        if (cm_init) begin
            cm_vld   <= '0;
            cm_dirty <= '0;
        end else begin
            if (if0.c_write_en && if0.c_hit) begin
                cm_data[w_idx][{w_word, 5'd0} +: 32] <= if0.c_write_data;
                cm_dirty[w_idx] <= 1'b1;
            end
            if (if0.c_refill_done) begin
                cm_data[w_idx]  <= if0.c_refill_block;
                cm_tag[w_idx]   <= w_tag;
                cm_vld[w_idx]   <= 1'b1;
                cm_dirty[w_idx] <= 1'b0;
            end
        end
    end

    int n_refill, n_memreq;
    always @(posedge clk) begin
        if (if0.c_refill_done) n_refill <= n_refill + 1;
        if (if0.mem_req)       n_memreq <= n_memreq + 1;
    end

    int n_vec, n_err;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [15:0] a, input logic [31:0] d);
        chk("ready_before_req", if0.cpu_ready, 1'b1);
        if0.cpu_req_valid = 1'b1;
        if0.cpu_req_we    = we;
        if0.cpu_addr      = a;
        if0.cpu_wdata     = d;
        @(posedge clk);
        @(negedge clk);
        if0.cpu_req_valid = 1'b0;
    endtask

    // lat counts cycles including the acceptance cycle.
    task automatic wait_resp(output int lat);
        int n = 1;
        while (!if0.cpu_resp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("resp_seen", if0.cpu_resp_valid, 1'b1);
        lat = n + 1;
    endtask

    task automatic mem_serve(input logic [15:0] ea, input logic ewe, input int waitc,
                             input logic [BW-1:0] rd, output logic [BW-1:0] wd);
        int n = 0;
        while (!if0.mem_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("mem_req", if0.mem_req, 1'b1);
        chk("mem_addr", if0.mem_addr, ea);
        chk("mem_we", if0.mem_we, ewe);
        wd = if0.mem_wdata;
        repeat (waitc) @(negedge clk);
        chk("mem_hold", {if0.mem_req, if0.mem_we, if0.mem_addr}, {1'b1, ewe, ea});
        chk("mem_wdata_hold", if0.mem_wdata, wd);
        if0.mem_ack   = 1'b1;
        if0.mem_rdata = rd;
        @(negedge clk);
        if0.mem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected $finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [BW-1:0] blk, blk2, wd;
        int lat, r0, m0;

        rst = 1'b1;
        cm_init = 1'b1;
        if0.cpu_req_valid = 1'b0;
        if0.cpu_req_we    = 1'b0;
        if0.cpu_addr      = '0;
        if0.cpu_wdata     = '0;
        if0.mem_ack       = 1'b0;
        if0.mem_rdata     = '0;
        repeat (3) @(negedge clk);

        chk("rst_ready", if0.cpu_ready, 1'b1);
        chk("rst_ctrl", {if0.cpu_resp_valid, if0.mem_req, if0.mem_we, if0.c_read_en,
                         if0.c_write_en, if0.c_refill_done}, 6'b0);
        chk("rst_cnts", {if0.hit_cnt, if0.miss_cnt, if0.wb_cnt}, 48'h0);
        chk("rst_rdata", if0.cpu_rdata, 32'h0);
        chk("rst_refill_blk", if0.c_refill_block, '0);
        rst = 1'b0;
        cm_init = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", if0.cpu_ready, 1'b1);

        // Clean miss on an empty cache
        r0 = n_refill;
        issue(1'b0, 16'h0040, 32'h0);
        chk("t1_lookup_en", {if0.c_read_en, if0.c_write_en}, 2'b10);
        chk("t1_caddr", if0.c_address, 16'h0040);
        blk = '0;
        blk[31:0]  = 32'hA5A5A5A5;
        blk[63:32] = 32'h0BAD0001;
        mem_serve(16'h0040, 1'b0, 4, blk, wd);
        chk("t1_refill_done", if0.c_refill_done, 1'b1);
        chk("t1_refill_blk", if0.c_refill_block, blk);
        chk("t1_no_memreq_install", if0.mem_req, 1'b0);
        wait_resp(lat);
        chk("t1_rdata", if0.cpu_rdata, 32'hA5A5A5A5);
        chk("t1_cnts", {if0.hit_cnt, if0.miss_cnt, if0.wb_cnt}, {16'd0, 16'd1, 16'd0});
        chk("t1_refills", n_refill - r0, 1);
        @(negedge clk);
        chk("t1_resp_pulse", {if0.cpu_resp_valid, if0.cpu_ready}, 2'b01);

        // Read hit on the same line
        m0 = n_memreq;
        issue(1'b0, 16'h0040, 32'h0);
        wait_resp(lat);
        chk("t2_hit_latency", lat, 3);
        chk("t2_rdata", if0.cpu_rdata, 32'hA5A5A5A5);
        chk("t2_hit_cnt", if0.hit_cnt, 16'd1);
        chk("t2_no_mem", n_memreq - m0, 0);
        @(negedge clk);
        chk("t2_resp_pulse", if0.cpu_resp_valid, 1'b0);

        // Write hit, then a conflicting read forcing a dirty writeback
        issue(1'b1, 16'h0044, 32'hDEADBEEF);
        chk("t3_lookup_en", {if0.c_read_en, if0.c_write_en}, 2'b01);
        chk("t3_wfields", {if0.c_address, if0.c_write_data}, {16'h0044, 32'hDEADBEEF});
        wait_resp(lat);
        chk("t3_whit_latency", lat, 3);
        chk("t3_rdata_held", if0.cpu_rdata, 32'hA5A5A5A5);
        chk("t3_hit_cnt", if0.hit_cnt, 16'd2);
        @(negedge clk);

        r0 = n_refill;
        issue(1'b0, 16'h0444, 32'h0);
        chk("t3_caddr", if0.c_address, 16'h0444);
        mem_serve(16'h0040, 1'b1, 2, '0, wd);
        chk("t3_wb_word0", wd[31:0], 32'hA5A5A5A5);
        chk("t3_wb_word1", wd[63:32], 32'hDEADBEEF);
        blk2 = '0;
        blk2[63:32] = 32'h12345678;
        mem_serve(16'h0440, 1'b0, 3, blk2, wd);
        wait_resp(lat);
        chk("t3_rdata", if0.cpu_rdata, 32'h12345678);
        chk("t3_cnts", {if0.hit_cnt, if0.miss_cnt, if0.wb_cnt}, {16'd2, 16'd2, 16'd1});
        chk("t3_refills", n_refill - r0, 1);
        @(negedge clk);

        // Saturation: narrow copy is one below all-ones here
        chk("sat_pre", {if1.hit_cnt, if1.miss_cnt, if1.wb_cnt}, 6'b10_10_01);
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 16'h0444, 32'h0);
            wait_resp(lat);
            @(negedge clk);
        end
        chk("sat_hit", if1.hit_cnt, 2'b11);
        chk("sat_wide_hit", if0.hit_cnt, 16'd5);

        // Stray mem_ack in IDLE and RESPOND
        m0 = n_memreq;
        if0.mem_ack = 1'b1;
        @(negedge clk);
        if0.mem_ack = 1'b0;
        chk("t6_idle_ack", {if0.cpu_ready, if0.mem_req}, 2'b10);
        issue(1'b0, 16'h0444, 32'h0);
        @(negedge clk);
        chk("t6_in_respond", if0.cpu_resp_valid, 1'b1);
        if0.mem_ack = 1'b1;
        @(negedge clk);
        if0.mem_ack = 1'b0;
        chk("t6_resp_ack", {if0.cpu_ready, if0.cpu_resp_valid, if0.mem_req}, 3'b100);
        chk("t6_no_mem", n_memreq - m0, 0);
        chk("t6_hit_cnt", if0.hit_cnt, 16'd6);

        // Reset in the middle of a refill
        r0 = n_refill;
        issue(1'b0, 16'h0840, 32'h0);
        @(negedge clk);
        chk("t4_in_refill", {if0.mem_req, if0.mem_addr}, {1'b1, 16'h0840});
        #2 rst = 1'b1;
        #1;
        chk("t4_async_memreq", if0.mem_req, 1'b0);
        chk("t4_ready", if0.cpu_ready, 1'b1);
        chk("t4_cnts", {if0.hit_cnt, if0.miss_cnt, if0.wb_cnt}, 48'h0);
        chk("t4_regs", {if0.cpu_rdata, if0.c_refill_block}, '0);
        @(negedge clk);
        if0.mem_ack   = 1'b1;
        if0.mem_rdata = blk;
        @(negedge clk);
        if0.mem_ack = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        if0.mem_ack = 1'b1;
        @(negedge clk);
        if0.mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4_after", {if0.cpu_ready, if0.mem_req, if0.c_refill_done}, 3'b100);
        chk("t4_no_install", n_refill - r0, 0);
        chk("t4_miss_cnt", if0.miss_cnt, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
